// File: rtl/video_timing_ctrl.sv
// Programmable raster sequencer: pixel counters, syncs and display enable for the DVI path,
// with double-buffered timing registers and a per-line prefetch request handshake.
module video_timing_ctrl #(
  parameter logic [11:0] H_ACTIVE     = 12'd640,
  parameter logic [11:0] H_SYNC_START = 12'd656,
  parameter logic [11:0] H_SYNC_END   = 12'd752,
  parameter logic [11:0] H_TOTAL      = 12'd800,
  parameter logic [11:0] V_ACTIVE     = 12'd480,
  parameter logic [11:0] V_SYNC_START = 12'd490,
  parameter logic [11:0] V_SYNC_END   = 12'd492,
  parameter logic [11:0] V_TOTAL      = 12'd525,
  parameter logic        HS_POL       = 1'b1,
  parameter logic        VS_POL       = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_wr,
  input  logic [2:0]  cfg_addr,
  input  logic [11:0] cfg_wdata,
  input  logic        cfg_commit,
  output logic        commit_pending,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start,
  output logic        line_req,
  output logic [11:0] line_req_y,
  input  logic        line_ack,
  output logic        underrun
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_REQ  = 1'b1;

  function automatic logic [11:0] default_reg(input logic [2:0] idx);
    case (idx)
      3'd0:    return H_ACTIVE;
      3'd1:    return H_SYNC_START;
      3'd2:    return H_SYNC_END;
      3'd3:    return H_TOTAL;
      3'd4:    return V_ACTIVE;
      3'd5:    return V_SYNC_START;
      3'd6:    return V_SYNC_END;
      default: return V_TOTAL;
    endcase
  endfunction

  logic [11:0] shadow_regs [8];
  logic [11:0] active_regs [8];
  logic [11:0] hc, vc;
  logic [11:0] h_active, h_sync_start, h_sync_end, h_total;
  logic [11:0] v_active, v_sync_start, v_sync_end, v_total;
  logic [11:0] vc_plus1;
  logic        hc_last, vc_last, frame_end;
  logic [0:0]  state;

  assign h_active     = active_regs[0];
  assign h_sync_start = active_regs[1];
  assign h_sync_end   = active_regs[2];
  assign h_total      = active_regs[3];
  assign v_active     = active_regs[4];
  assign v_sync_start = active_regs[5];
  assign v_sync_end   = active_regs[6];
  assign v_total      = active_regs[7];

  // Compare with >= so a shrunken total cannot leave the counters running away.
  assign hc_last   = (hc >= h_total - 12'd1);
  assign vc_last   = (vc >= v_total - 12'd1);
  assign frame_end = hc_last && vc_last;
  assign vc_plus1  = vc + 12'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        shadow_regs[i] <= default_reg(3'(i));
        active_regs[i] <= default_reg(3'(i));
      end
    end else begin
      // The copy reads the old shadow, so a same-cycle write only takes effect at a later commit.
      if (frame_end && commit_pending) begin
        for (int i = 0; i < 8; i++) begin
          active_regs[i] <= shadow_regs[i];
        end
      end
      if (cfg_wr) begin
        shadow_regs[cfg_addr] <= cfg_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      commit_pending <= 1'b0;
    end else if (cfg_commit) begin
      commit_pending <= 1'b1;
    end else if (frame_end) begin
      commit_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hc <= '0;
      vc <= '0;
    end else if (hc_last) begin
      hc <= '0;
      vc <= vc_last ? 12'd0 : vc_plus1;
    end else begin
      hc <= hc + 12'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x           <= '0;
      y           <= '0;
      de          <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      frame_start <= 1'b0;
    end else begin
      x           <= hc;
      y           <= vc;
      de          <= (hc < h_active) && (vc < v_active);
      hsync       <= ((hc >= h_sync_start) && (hc < h_sync_end)) ? HS_POL : ~HS_POL;
      vsync       <= ((vc >= v_sync_start) && (vc < v_sync_end)) ? VS_POL : ~VS_POL;
      frame_start <= (hc == 12'd0) && (vc == 12'd0);
    end
  end

  // Prefetch the next visible line once the current one leaves the active area; the deadline is line end.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      line_req_y <= '0;
      underrun   <= 1'b0;
    end else begin
      underrun <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (hc == h_active) begin
            if (vc_plus1 < v_active) begin
              state      <= ST_REQ;
              line_req_y <= vc_plus1;
            end else if (vc == v_total - 12'd1) begin
              state      <= ST_REQ;
              line_req_y <= 12'd0;
            end
          end
        end
        ST_REQ: begin
          if (line_ack) begin
            state <= ST_IDLE;
          end else if (hc_last) begin
            state    <= ST_IDLE;
            underrun <= 1'b1;
          end
        end
      endcase
    end
  end

  assign line_req = (state == ST_REQ);

endmodule
